// File: rtl/fpu_dram_responder.sv
// fpu_dram_responder: behavioural DRAM side of the FPU cache-line burst protocol over a line-wide array.
// Define FPUDRAM_BOUNDS_CHK_EN to reject bursts running past the end of the array (bounds_err).
module fpu_dram_responder #(
    parameter int MEM_LINES = 1024,
    parameter int LINE_AW   = $clog2(MEM_LINES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         request,
    input  logic         rd_wr,
    input  logic [31:0]  address,
    input  logic [7:0]   request_size,
    input  logic         fpu_ready,
    input  logic [511:0] write_data,
    output logic         dram_ready,
    output logic [511:0] read_data,
    output logic         request_done,
    output logic         bounds_err
);
    localparam logic [2:0] IDLE = 3'd0, RD_FETCH = 3'd1, RD_SEND = 3'd2, WR_RECV = 3'd3, DONE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [LINE_AW-1:0] idx_q, idx_d;
    logic [7:0]         rem_q, rem_d;
    logic [511:0]       rdata_q;
    logic [511:0]       mem [MEM_LINES];
    logic [LINE_AW-1:0] base;
    logic               reject, last, rd_en, unused_addr;

    assign base         = address[LINE_AW+5:6];
    assign unused_addr  = ^{address[31:LINE_AW+6], address[5:0]};
    assign last         = rem_q == 8'd1;
    assign dram_ready   = state_q == WR_RECV || (state_q == RD_SEND && fpu_ready);
    assign read_data    = rdata_q;
    assign request_done = state_q == DONE;
    // the next line is prefetched on the beat so back-to-back beats need no bubble
    assign rd_en        = state_q == RD_FETCH || (state_q == RD_SEND && fpu_ready && !last);

`ifdef FPUDRAM_BOUNDS_CHK_EN
    logic                 err_q, err_d;
    logic [LINE_AW+8:0]   span;
    assign span       = (LINE_AW+9)'(base) + (LINE_AW+9)'(request_size);
    assign reject     = span > (LINE_AW+9)'(MEM_LINES);
    assign err_d      = (state_q == IDLE && request) ? reject : err_q;
    assign bounds_err = request_done && err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign reject     = 1'b0;
    assign bounds_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (request) begin
                idx_d   = base;
                rem_d   = request_size;
                state_d = (request_size == 8'd0 || reject) ? DONE : rd_wr ? WR_RECV : RD_FETCH;
            end
            RD_FETCH: state_d = RD_SEND;
            RD_SEND, WR_RECV: if (fpu_ready) begin
                idx_d   = idx_q + LINE_AW'(1);
                rem_d   = rem_q - 8'd1;
                state_d = last ? DONE : state_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            if (rd_en) rdata_q <= mem[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == WR_RECV && fpu_ready) mem[idx_q] <= write_data;
    end
endmodule

// File: tb/tb_fpu_dram_responder.sv
// tb_fpu_dram_responder: directed bursts with a read-beat/completion scoreboard checked by a negedge monitor.
module tb_fpu_dram_responder;
    localparam int ML = 1024;

    logic         clk = 0, rst = 1, request = 0, rd_wr = 0, fpu_ready = 0;
    logic [31:0]  address = 0;
    logic [7:0]   request_size = 0;
    logic [511:0] write_data = 0;
    logic         dram_ready, request_done, bounds_err;
    logic [511:0] read_data;

    int checks = 0, errors = 0, done_cnt = 0, cyc = 0;
    int done_cyc[$];
    logic [511:0] model [int];
    logic [511:0] rq[$];
    logic         dq[$];
    logic         rd_mode = 0, stall_prev = 0;
    logic [511:0] prev_data = 0;

    fpu_dram_responder #(.MEM_LINES(ML)) dut (
        .clk(clk), .rst(rst), .request(request), .rd_wr(rd_wr), .address(address),
        .request_size(request_size), .fpu_ready(fpu_ready), .write_data(write_data),
        .dram_ready(dram_ready), .read_data(read_data), .request_done(request_done),
        .bounds_err(bounds_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s unexpected event", nm);
    endtask

    function automatic logic [511:0] pat(input int seed, input int line);
        return {16{seed[15:0], line[15:0]}};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_mode && dram_ready && fpu_ready) begin
                if (rq.size() == 0) fail_now("extra_beat");
                else check("beat", read_data, rq.pop_front());
            end
            if (rd_mode && !fpu_ready) check("rdy_gate", dram_ready, 0);
            if (stall_prev) check("stall_hold", read_data, prev_data);
            stall_prev = rd_mode && !fpu_ready;
            prev_data  = read_data;
            if (request_done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                if (dq.size() == 0) fail_now("extra_done");
                else check("bounds_err", bounds_err, dq.pop_front());
            end
        end
    end

    task automatic wait_done(input int s);
        for (int k = 0; k < 40 && done_cnt == s; k++) step;
        check("done_seen", done_cnt != s, 1);
    endtask

    task automatic wr(input int line, input int n, input int seed);
        logic err;
        int s;
        err = 0;
`ifdef FPUDRAM_BOUNDS_CHK_EN
        err = (line + n > ML);
`endif
        dq.push_back(err);
        step;
        request = 1; rd_wr = 1; address = 32'(line * 64) | 32'h15; request_size = 8'(n);
        fpu_ready = (n == 0); write_data = '1;
        step;
        request = 0; s = done_cnt;
        if (n == 0 || err) begin
            check("wr_done_t1", {request_done, bounds_err, dram_ready}, {1'b1, err, 1'b0});
        end else begin
            check("wr_rdy_t1", dram_ready, 1);
            for (int k = 0; k < n; k++) begin
                fpu_ready = 1;
                write_data = pat(seed, line + k);
                model[(line + k) % ML] = write_data;
                step;
            end
        end
        fpu_ready = 0;
        wait_done(s);
    endtask

    task automatic rd(input int line, input int n, input logic [7:0] rp, input int plen);
        int s;
        for (int k = 0; k < n; k++) rq.push_back(model[(line + k) % ML]);
        dq.push_back(0);
        step;
        request = 1; rd_wr = 0; address = 32'(line * 64); request_size = 8'(n);
        step;
        request = 0; fpu_ready = 1; rd_mode = 1; s = done_cnt;
        check("rd_t1_rdy", dram_ready, 0);
        if (n == 0) check("rd0_done_t1", request_done, 1);
        for (int k = 0; k < 40 && done_cnt == s; k++) begin
            step;
            fpu_ready = (k < plen) ? rp[k] : 1'b1;
            if (k == 0 && n > 0) begin
                #1 check("rd_lat_t2", dram_ready, fpu_ready);
            end
        end
        check("rd_done", done_cnt != s, 1);
        check("rd_drain", 512'(rq.size()), 0);
        rd_mode = 0; fpu_ready = 0;
    endtask

    initial begin
        int s;
        repeat (3) step;
        check("reset_out", {dram_ready, request_done, bounds_err, read_data}, '0);
        rst = 0;

        wr(4, 4, 0);
        rd(4, 4, 8'h0, 0);

        wr(8, 3, 3);
        rd(8, 3, 8'b11001, 5);

        wr(4, 0, 0);
        rd(4, 0, 8'h0, 0);
        rd(4, 4, 8'h0, 0);

        wr(1023, 1, 5);
        wr(0, 1, 6);
        wr(1023, 2, 7);
        rd(1023, 1, 8'h0, 0);
        rd(0, 1, 8'h0, 0);

        wr(0, 3, 1);
        step;
        request = 1; rd_wr = 1; address = 0; request_size = 8;
        step;
        request = 0; s = done_cnt;
        for (int k = 0; k < 2; k++) begin
            fpu_ready = 1;
            write_data = pat(2, k);
            model[k] = write_data;
            step;
        end
        rst = 1; fpu_ready = 0;
        step;
        check("rst_mid_out", {dram_ready, request_done, bounds_err, read_data}, '0);
        rst = 0;
        repeat (12) step;
        check("rst_no_done", 512'(done_cnt), 512'(s));
        rd(0, 3, 8'h0, 0);

        for (int r = 0; r < 2; r++) begin
            dq.push_back(0);
            rq.push_back(model[4]);
            rq.push_back(model[5]);
        end
        step;
        request = 1; rd_wr = 0; address = 32'(4 * 64); request_size = 2; fpu_ready = 1; rd_mode = 1;
        s = done_cnt;
        for (int k = 0; k < 40 && done_cnt == s; k++) step;
        step;
        request = 0;
        for (int k = 0; k < 40 && done_cnt < s + 2; k++) step;
        check("b2b_dones", 512'(done_cnt - s), 2);
        if (done_cyc.size() >= 2)
            check("b2b_gap", 512'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 5);
        check("b2b_drain", 512'(rq.size()), 0);
        rd_mode = 0; fpu_ready = 0;
        repeat (4) step;
        check("final_dq", 512'(dq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
